// File: rtl/rv32im_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32im_mem_arbiter
// Description : Shares one data-memory port between the IFU (read-only) and
//               the LSU (read/write with byte mask). One outstanding access,
//               ack-terminated, LSU priority with an IFU starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32im_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // instruction fetch port
    input  logic                    ifu_req_i,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
    output logic                    ifu_gnt_o,
    output logic                    ifu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
    // load/store port
    input  logic                    lsu_req_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_wr_mask_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
    // memory port
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wr_mask_o,
    input  logic                    mem_ack_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IFU = 2'd1,
        BUSY_LSU = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
    logic                    ifu_gnt_q, ifu_gnt_d;
    logic                    lsu_gnt_q, lsu_gnt_d;
    logic                    ifu_rvalid_q, ifu_rvalid_d;
    logic                    lsu_rvalid_q, lsu_rvalid_d;
    logic [DATA_WIDTH-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_WIDTH-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                    mem_en_q, mem_en_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]       mem_wr_mask_q, mem_wr_mask_d;

    logic                    lsu_wins;

    // LSU takes a contested slot unless the IFU has already lost STARVE_LIMIT times in a row
    assign lsu_wins = lsu_req_i && !(ifu_req_i && (starve_cnt_q == STARVE_MAX));

    // Next-state, arbitration and response capture
    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        ifu_gnt_d     = 1'b0;
        lsu_gnt_d     = 1'b0;
        ifu_rvalid_d  = 1'b0;
        lsu_rvalid_d  = 1'b0;
        ifu_rdata_d   = ifu_rdata_q;
        lsu_rdata_d   = lsu_rdata_q;
        mem_en_d      = mem_en_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wr_mask_d = mem_wr_mask_q;

        unique case (state_q)
            IDLE: begin
                if (lsu_wins) begin
                    state_d       = BUSY_LSU;
                    lsu_gnt_d     = 1'b1;
                    mem_en_d      = 1'b1;
                    mem_addr_d    = lsu_addr_i;
                    // a load drives no store data onto the bus
                    mem_wdata_d   = (lsu_wr_mask_i == '0) ? '0 : lsu_wdata_i;
                    mem_wr_mask_d = lsu_wr_mask_i;
                    if (ifu_req_i) begin
                        starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                                    : starve_cnt_q + 1'b1;
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (ifu_req_i) begin
                    state_d       = BUSY_IFU;
                    ifu_gnt_d     = 1'b1;
                    mem_en_d      = 1'b1;
                    mem_addr_d    = ifu_addr_i;
                    mem_wdata_d   = '0;
                    mem_wr_mask_d = '0;
                    starve_cnt_d  = '0;
                end
            end
            BUSY_IFU: begin
                if (mem_ack_i) begin
                    state_d       = IDLE;
                    ifu_rvalid_d  = 1'b1;
                    ifu_rdata_d   = mem_rdata_i;
                    mem_en_d      = 1'b0;
                    mem_wdata_d   = '0;
                    mem_wr_mask_d = '0;
                end
            end
            BUSY_LSU: begin
                if (mem_ack_i) begin
                    state_d      = IDLE;
                    lsu_rvalid_d = 1'b1;
                    // stores complete without touching the load data register
                    if (mem_wr_mask_q == '0) begin
                        lsu_rdata_d = mem_rdata_i;
                    end
                    mem_en_d      = 1'b0;
                    mem_wdata_d   = '0;
                    mem_wr_mask_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            ifu_gnt_q     <= 1'b0;
            lsu_gnt_q     <= 1'b0;
            ifu_rvalid_q  <= 1'b0;
            lsu_rvalid_q  <= 1'b0;
            ifu_rdata_q   <= '0;
            lsu_rdata_q   <= '0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wr_mask_q <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            ifu_gnt_q     <= ifu_gnt_d;
            lsu_gnt_q     <= lsu_gnt_d;
            ifu_rvalid_q  <= ifu_rvalid_d;
            lsu_rvalid_q  <= lsu_rvalid_d;
            ifu_rdata_q   <= ifu_rdata_d;
            lsu_rdata_q   <= lsu_rdata_d;
            mem_en_q      <= mem_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wr_mask_q <= mem_wr_mask_d;
        end
    end

    assign ifu_gnt_o     = ifu_gnt_q;
    assign lsu_gnt_o     = lsu_gnt_q;
    assign ifu_rvalid_o  = ifu_rvalid_q;
    assign lsu_rvalid_o  = lsu_rvalid_q;
    assign ifu_rdata_o   = ifu_rdata_q;
    assign lsu_rdata_o   = lsu_rdata_q;
    assign mem_en_o      = mem_en_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_wr_mask_o = mem_wr_mask_q;

endmodule
`default_nettype wire

// File: doc/rv32im_mem_arbiter.md
# rv32im_mem_arbiter

Two-requester arbiter that shares the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write with byte mask). It sits between those units and memory, immediately on the memory side of the LSU byte-lane formatter. It serialises transactions with one outstanding access at a time, tolerates variable memory latency via an acknowledge, and gives the LSU priority with a starvation guard for the IFU.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; the byte mask is `DATA_WIDTH/8` bits.
- `STARVE_LIMIT`, 4, consecutive contested LSU wins before the IFU is forced through; must be ≥1.

- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `ifu_req_i` in 1: IFU read request; held with address until grant.
- `ifu_addr_i` in ADDR_WIDTH: IFU address.
- `ifu_gnt_o` out 1: one-cycle pulse; IFU request accepted.
- `ifu_rvalid_o` out 1: one-cycle pulse; `ifu_rdata_o` valid.
- `ifu_rdata_o` out DATA_WIDTH: IFU read data, registered.
- `lsu_req_i` in 1: LSU request; held with all fields until grant.
- `lsu_addr_i` in ADDR_WIDTH: LSU address.
- `lsu_wdata_i` in DATA_WIDTH: store data, already lane-aligned.
- `lsu_wr_mask_i` in DATA_WIDTH/8: byte enables; all-zero = load.
- `lsu_gnt_o` out 1: one-cycle pulse; LSU request accepted.
- `lsu_rvalid_o` out 1: one-cycle pulse; load data valid or store complete.
- `lsu_rdata_o` out DATA_WIDTH: LSU load data, registered.
- `mem_en_o` out 1: memory access active.
- `mem_addr_o` out ADDR_WIDTH: latched address.
- `mem_wdata_o` out DATA_WIDTH: latched store data (0 for reads).
- `mem_wr_mask_o` out DATA_WIDTH/8: latched mask (0 for reads and IFU).
- `mem_ack_i` in 1: memory completes the access this cycle; qualified by `mem_en_o`.
- `mem_rdata_i` in DATA_WIDTH: read data, valid while `mem_ack_i` is high.

## Operation
- State machine has three states: `IDLE`, `BUSY_IFU`, `BUSY_LSU`. A 1-bit owner register together with `mem_en_o` is equivalent.
- In `IDLE`, with any request pending at a clock edge, the arbiter selects a winner:
  - Only one requester: that requester wins.
  - Both requesting: LSU wins unless `starve_cnt == STARVE_LIMIT`, in which case IFU wins.
- On selection, the arbiter latches the winner's addr, wdata and mask into the `mem_*` registers, sets `mem_en_o`, pulses the winner's `gnt_o`, and moves to `BUSY_*`. IFU selection latches `wdata = 0` and `mask = 0`.
- `starve_cnt` (width ≥ clog2(STARVE_LIMIT+1)) is updated on every selection:
  - LSU wins while `ifu_req_i` is high: increment, saturating.
  - IFU wins: clear to 0.
  - LSU wins while `ifu_req_i` is low: clear to 0.
- In `BUSY_*`, all requests are ignored. When `mem_ack_i` is high at the edge:
  - Pulse the owner's `rvalid_o`.
  - For reads (IFU, or LSU with zero mask), load the owner's `rdata_o` with `mem_rdata_i`. Stores leave `lsu_rdata_o` unchanged.
  - Clear `mem_en_o`, `mem_wdata_o` and `mem_wr_mask_o`. `mem_addr_o` holds its value.
  - Return to `IDLE`.
- The arbiter does not modify data; lane formatting and sign extension are the LSU's job.
- There is no timeout. The arbiter waits in `BUSY_*` indefinitely until `mem_ack_i`.

## Timing
- Reset (asynchronous, at any time including mid-transaction): state `IDLE`, `starve_cnt` 0, and every output 0 (`gnt`, `rvalid`, `rdata`, all `mem_*`). An in-flight access is abandoned and no `rvalid` is produced for it.
- Cycle N: request seen in `IDLE`.
- Cycle N+1: `gnt_o` = 1 and `mem_en_o` = 1 with valid addr, wdata and mask. The requester may drop or change its request from this cycle on.
- Cycle M ≥ N+1: `mem_ack_i` = 1.
- Cycle M+1: `rvalid_o` = 1 with `rdata_o` valid, `mem_en_o` = 0, state `IDLE`. A request present in M+1 is granted in M+2.
- Zero-wait memory therefore gives a 2-cycle request-to-data latency and one transaction per 2 cycles.
- `mem_ack_i` while `mem_en_o` = 0 is ignored.
- `gnt` and `rvalid` pulses are never asserted to both requesters in the same cycle, and `rvalid` is never asserted without a preceding `gnt`.
- A request dropped before grant is simply never served; no state is kept for it.

## Test plan
- Single IFU read, addr 0x100, ack in the cycle after `gnt`, `mem_rdata_i` 0xDEADBEEF -> `ifu_gnt_o` at N+1, `ifu_rvalid_o` at N+3 with 0xDEADBEEF, `mem_wr_mask_o` 0 throughout.
- LSU store, addr 0x204, mask 4'b1100, wdata 0xABCD0000, ack after 3 wait cycles -> `mem_*` hold those values for 4 cycles, `lsu_rvalid_o` pulses once, `lsu_rdata_o` unchanged, mask is 0 after completion.
- Both requesting continuously, zero-wait memory, `STARVE_LIMIT` 4 -> grant order LSU,LSU,LSU,LSU,IFU repeating; `starve_cnt` returns to 0 after each IFU grant.
- LSU grant while `ifu_req_i` is low, then both requesting -> LSU wins and `starve_cnt` becomes 1 (cleared first, then incremented from 0 only for the contested grant).
- Assert `rst_i` in the middle of a `BUSY_LSU` load -> all outputs read 0 immediately without a clock edge; after release, a late `mem_ack_i` produces no `rvalid`.
- Spurious `mem_ack_i` in `IDLE` and requests toggled during `BUSY` -> no `rvalid`, no state change, no extra grants.
